// File: rtl/pe_stream_sched_pkg.sv
// Shared definitions for the per-PE stream scheduler: cfg field layout, phase encoding
// and the per-phase word-count rule.
package pe_stream_sched_pkg;

  localparam int CFG_W  = 13;
  localparam int CFG_DW = 12;
  localparam int RS_LSB = 10;
  localparam int U_BIT  = 9;
  localparam int P_LSB  = 7;
  localparam int F_LSB  = 2;
  localparam int Q_LSB  = 0;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_CFG,
    PH_FILTER,
    PH_IFMAP,
    PH_DW_IPSUM,
    PH_PW_IPSUM,
    PH_OPSUM,
    PH_DONE
  } phase_e;

  // Words the PE consumes/produces in a phase; cfg fields are stored minus one.
  function automatic logic [4:0] phase_count(input phase_e ph, input logic [CFG_W-1:0] c,
                                             input logic first_col);
    logic [4:0] p, q, rs, u;
    p  = {3'd0, c[P_LSB+:2]} + 5'd1;
    q  = {3'd0, c[Q_LSB+:2]} + 5'd1;
    rs = {3'd0, c[RS_LSB+:2]} + 5'd1;
    u  = {4'd0, c[U_BIT]} + 5'd1;
    case (ph)
      PH_FILTER:             phase_count = p * rs;
      PH_IFMAP:              phase_count = first_col ? rs : u;
      PH_DW_IPSUM:           phase_count = c[CFG_DW] ? q : p;
      PH_PW_IPSUM, PH_OPSUM: phase_count = p;
      default:               phase_count = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/pe_chan_demux.sv
// Steers upstream valid/ready onto the PE channel selected by the current phase.
// Purely combinational; a stalled side simply holds the other side's valid/ready low.
module pe_chan_demux
  import pe_stream_sched_pkg::*;
(
  input  phase_e phase_i,
  input  logic   in_valid_i,
  input  logic   filter_ready_i,
  input  logic   ifmap_ready_i,
  input  logic   dw_ready_i,
  input  logic   pw_ready_i,
  input  logic   opsum_valid_i,
  input  logic   out_ready_i,
  output logic   filter_valid_o,
  output logic   ifmap_valid_o,
  output logic   dw_valid_o,
  output logic   pw_valid_o,
  output logic   in_ready_o,
  output logic   out_valid_o,
  output logic   opsum_ready_o
);

  always_comb begin
    filter_valid_o = 1'b0;
    ifmap_valid_o  = 1'b0;
    dw_valid_o     = 1'b0;
    pw_valid_o     = 1'b0;
    in_ready_o     = 1'b0;
    out_valid_o    = 1'b0;
    opsum_ready_o  = 1'b0;
    case (phase_i)
      PH_FILTER: begin
        filter_valid_o = in_valid_i;
        in_ready_o     = filter_ready_i;
      end
      PH_IFMAP: begin
        ifmap_valid_o = in_valid_i;
        in_ready_o    = ifmap_ready_i;
      end
      PH_DW_IPSUM: begin
        dw_valid_o = in_valid_i;
        in_ready_o = dw_ready_i;
      end
      PH_PW_IPSUM: begin
        pw_valid_o = in_valid_i;
        in_ready_o = pw_ready_i;
      end
      PH_OPSUM: begin
        out_valid_o   = opsum_valid_i;
        opsum_ready_o = out_ready_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pe_stream_sched.sv
// Job sequencer for one PE: config pulse, then filter/ifmap/ipsum/opsum phases per column.
// Handshakes pass through with zero latency; stalls on either side freeze state and counters.
module pe_stream_sched
  import pe_stream_sched_pkg::*;
#(
  parameter int DATA_BITS   = 32,
  parameter int CONFIG_SIZE = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CONFIG_SIZE-1:0] cfg,
  output logic                   busy,
  output logic                   done,
  input  logic [DATA_BITS-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_BITS-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   PE_en,
  output logic [CONFIG_SIZE-1:0] i_config,
  output logic [DATA_BITS-1:0]   ifmap,
  output logic [DATA_BITS-1:0]   filter,
  output logic [DATA_BITS-1:0]   depthwise_ipsum,
  output logic [DATA_BITS-1:0]   pointwise_ipsum,
  output logic                   ifmap_valid,
  output logic                   filter_valid,
  output logic                   depthwise_ipsum_valid,
  output logic                   pointwise_ipsum_valid,
  input  logic                   ifmap_ready,
  input  logic                   filter_ready,
  input  logic                   depthwise_ipsum_ready,
  input  logic                   pointwise_ipsum_ready,
  input  logic [DATA_BITS-1:0]   opsum,
  input  logic                   opsum_valid,
  output logic                   opsum_ready
);

  phase_e                 state_q;
  phase_e                 next_phase;
  logic [4:0]             word_cnt_q;
  logic [4:0]             col_cnt_q;
  logic [CONFIG_SIZE-1:0] cfg_q;
  logic [4:0]             phase_cnt;
  logic                   xfer;
  logic                   last_word;
  logic                   last_col;

  pe_chan_demux u_demux (
    .phase_i        (state_q),
    .in_valid_i     (in_valid),
    .filter_ready_i (filter_ready),
    .ifmap_ready_i  (ifmap_ready),
    .dw_ready_i     (depthwise_ipsum_ready),
    .pw_ready_i     (pointwise_ipsum_ready),
    .opsum_valid_i  (opsum_valid),
    .out_ready_i    (out_ready),
    .filter_valid_o (filter_valid),
    .ifmap_valid_o  (ifmap_valid),
    .dw_valid_o     (depthwise_ipsum_valid),
    .pw_valid_o     (pointwise_ipsum_valid),
    .in_ready_o     (in_ready),
    .out_valid_o    (out_valid),
    .opsum_ready_o  (opsum_ready)
  );

  assign filter          = in_data;
  assign ifmap           = in_data;
  assign depthwise_ipsum = in_data;
  assign pointwise_ipsum = in_data;
  assign out_data        = opsum;

  assign busy     = (state_q != PH_IDLE);
  assign done     = (state_q == PH_DONE);
  assign PE_en    = (state_q == PH_CFG);
  assign i_config = cfg_q;

  assign phase_cnt = phase_count(state_q, cfg_q, col_cnt_q == 5'd0);
  assign xfer      = (state_q == PH_OPSUM) ? (out_valid && out_ready) : (in_valid && in_ready);
  assign last_word = (word_cnt_q + 5'd1) == phase_cnt;
  assign last_col  = (col_cnt_q == cfg_q[F_LSB+:5]);

  always_comb begin
    next_phase = state_q;
    case (state_q)
      PH_FILTER:   next_phase = PH_IFMAP;
      PH_IFMAP:    next_phase = PH_DW_IPSUM;
      PH_DW_IPSUM: next_phase = cfg_q[CFG_DW] ? PH_PW_IPSUM : PH_OPSUM;
      PH_PW_IPSUM: next_phase = PH_OPSUM;
      PH_OPSUM:    next_phase = last_col ? PH_DONE : PH_IFMAP;
      default:     next_phase = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PH_IDLE;
      word_cnt_q <= '0;
      col_cnt_q  <= '0;
      cfg_q      <= '0;
    end else begin
      case (state_q)
        PH_IDLE: begin
          if (start) begin
            cfg_q      <= cfg;
            state_q    <= PH_CFG;
            word_cnt_q <= '0;
            col_cnt_q  <= '0;
          end
        end
        PH_CFG:  state_q <= PH_FILTER;
        PH_DONE: state_q <= PH_IDLE;
        default: begin
          if (xfer) begin
            if (last_word) begin
              word_cnt_q <= '0;
              state_q    <= next_phase;
              if (state_q == PH_OPSUM && !last_col) col_cnt_q <= col_cnt_q + 5'd1;
            end else begin
              word_cnt_q <= word_cnt_q + 5'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_stream_sched.sv
// Bench for pe_stream_sched: scoreboarded word order on every channel plus job-level checks.
module tb_pe_stream_sched;

  localparam logic [31:0] IBASE = 32'h1000_0000;
  localparam logic [31:0] OBASE = 32'hA000_0000;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [12:0] cfg;
  logic        busy, done;
  logic [31:0] in_data, out_data;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic        PE_en;
  logic [12:0] i_config;
  logic [31:0] ifmap, filter, depthwise_ipsum, pointwise_ipsum, opsum;
  logic        ifmap_valid, filter_valid, depthwise_ipsum_valid, pointwise_ipsum_valid;
  logic        ifmap_ready, filter_ready, depthwise_ipsum_ready, pointwise_ipsum_ready;
  logic        opsum_valid, opsum_ready;

  always #5 clk = ~clk;

  pe_stream_sched #(.DATA_BITS(32), .CONFIG_SIZE(13)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg(cfg), .busy(busy), .done(done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .PE_en(PE_en), .i_config(i_config),
    .ifmap(ifmap), .filter(filter), .depthwise_ipsum(depthwise_ipsum),
    .pointwise_ipsum(pointwise_ipsum),
    .ifmap_valid(ifmap_valid), .filter_valid(filter_valid),
    .depthwise_ipsum_valid(depthwise_ipsum_valid),
    .pointwise_ipsum_valid(pointwise_ipsum_valid),
    .ifmap_ready(ifmap_ready), .filter_ready(filter_ready),
    .depthwise_ipsum_ready(depthwise_ipsum_ready),
    .pointwise_ipsum_ready(pointwise_ipsum_ready),
    .opsum(opsum), .opsum_valid(opsum_valid), .opsum_ready(opsum_ready)
  );

  typedef struct packed {
    logic [2:0]  ch;
    logic        rdy;
    logic [31:0] dat;
  } exp_t;

  exp_t        exp_in[$];
  logic [31:0] exp_out[$];
  int n_cmp = 0, n_fail = 0;
  int in_idx = 0, op_idx = 0, in_push = 0, op_push = 0;
  int in_xfers = 0, out_xfers = 0, pe_en_cnt = 0, done_cnt = 0;
  bit rnd = 1'b0;

  logic [22:0] quiet_vec;
  assign quiet_vec = {busy, done, PE_en, i_config, filter_valid, ifmap_valid,
                      depthwise_ipsum_valid, pointwise_ipsum_valid, in_ready,
                      out_valid, opsum_ready};

  // Upstream source, PE sinks and opsum source: data always tracks the next word index.
  initial begin
    forever begin
      in_data = IBASE + 32'(in_idx);
      opsum   = OBASE + 32'(op_idx);
      if (rnd) begin
        in_valid              = ($urandom_range(0, 99) < 30);
        filter_ready          = ($urandom_range(0, 99) < 30);
        ifmap_ready           = ($urandom_range(0, 99) < 30);
        depthwise_ipsum_ready = ($urandom_range(0, 99) < 30);
        pointwise_ipsum_ready = ($urandom_range(0, 99) < 30);
        opsum_valid           = ($urandom_range(0, 99) < 30);
        out_ready             = ($urandom_range(0, 99) < 30);
      end else begin
        in_valid = 1'b1; filter_ready = 1'b1; ifmap_ready = 1'b1;
        depthwise_ipsum_ready = 1'b1; pointwise_ipsum_ready = 1'b1;
        opsum_valid = 1'b1; out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
    end
  end

  exp_t       m_obs, m_exp;
  logic [3:0] m_vv;
  logic [31:0] m_out;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_vv = {pointwise_ipsum_valid, depthwise_ipsum_valid, ifmap_valid, filter_valid};
        n_cmp++;
        if ((m_vv != 4'd0 && !in_valid) || $countones(m_vv) > 1 ||
            (in_valid && in_ready && m_vv == 4'd0)) begin
          n_fail++;
          $display("FAIL chan_guard: valids=%b in_valid=%b in_ready=%b, required one-hot valids only with in_valid",
                   m_vv, in_valid, in_ready);
        end
        if (in_valid && in_ready) begin
          if (filter_valid)               m_obs = '{ch: 3'd0, rdy: filter_ready, dat: filter};
          else if (ifmap_valid)           m_obs = '{ch: 3'd1, rdy: ifmap_ready, dat: ifmap};
          else if (depthwise_ipsum_valid) m_obs = '{ch: 3'd2, rdy: depthwise_ipsum_ready, dat: depthwise_ipsum};
          else if (pointwise_ipsum_valid) m_obs = '{ch: 3'd3, rdy: pointwise_ipsum_ready, dat: pointwise_ipsum};
          else                            m_obs = '{ch: 3'd7, rdy: 1'b0, dat: in_data};
          in_xfers++;
          in_idx++;
          n_cmp++;
          if (exp_in.size() == 0) begin
            n_fail++;
            $display("FAIL in_word: got ch=%0d data=%h, required no transfer", m_obs.ch, m_obs.dat);
          end else begin
            m_exp = exp_in.pop_front();
            if (m_obs !== m_exp) begin
              n_fail++;
              $display("FAIL in_word: got ch=%0d rdy=%0b data=%h, required ch=%0d rdy=%0b data=%h",
                       m_obs.ch, m_obs.rdy, m_obs.dat, m_exp.ch, m_exp.rdy, m_exp.dat);
            end
          end
        end
        if (opsum_valid && opsum_ready) op_idx++;
        if (out_valid && out_ready) begin
          out_xfers++;
          n_cmp++;
          if (exp_out.size() == 0) begin
            n_fail++;
            $display("FAIL out_word: got %h, required no transfer", out_data);
          end else begin
            m_out = exp_out.pop_front();
            if (out_data !== m_out) begin
              n_fail++;
              $display("FAIL out_word: got %h, required %h", out_data, m_out);
            end
          end
        end
        if (PE_en) pe_en_cnt++;
        if (done) done_cnt++;
      end
    end
  end

  task automatic push_in(input logic [2:0] ch, input int n);
    for (int k = 0; k < n; k++) begin
      exp_in.push_back('{ch: ch, rdy: 1'b1, dat: IBASE + 32'(in_push)});
      in_push++;
    end
  endtask

  task automatic push_job(input logic [12:0] c);
    int p, q, rs, u, f;
    bit dw;
    p  = int'(c[8:7]) + 1;
    q  = int'(c[1:0]) + 1;
    rs = int'(c[11:10]) + 1;
    u  = int'(c[9]) + 1;
    f  = int'(c[6:2]);
    dw = c[12];
    for (int col = 0; col <= f; col++) begin
      if (col == 0) push_in(3'd0, p * rs);
      push_in(3'd1, (col == 0) ? rs : u);
      push_in(3'd2, dw ? q : p);
      if (dw) push_in(3'd3, p);
      for (int k = 0; k < p; k++) begin
        exp_out.push_back(OBASE + 32'(op_push));
        op_push++;
      end
    end
  endtask

  task automatic start_job(input logic [12:0] c);
    push_job(c);
    @(posedge clk); #1;
    cfg   = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++;
    if (quiet_vec !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0", quiet_vec);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (quiet_vec !== 23'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h, required 0", quiet_vec);
    end
  endtask

  task automatic test_normal_conv;
    logic [12:0] c;
    int i0, o0, p0, d0;
    bit seen;
    c  = {1'b0, 2'd2, 1'b0, 2'd1, 5'd1, 2'd0};
    i0 = in_xfers; o0 = out_xfers; p0 = pe_en_cnt; d0 = done_cnt;
    push_job(c);
    @(posedge clk); #1;
    cfg = c; start = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || PE_en !== 1'b0) begin
      n_fail++;
      $display("FAIL conv_pre_accept: busy=%b PE_en=%b, required 0 0", busy, PE_en);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, PE_en, i_config} !== {1'b1, 1'b1, c}) begin
      n_fail++;
      $display("FAIL conv_cfg_pulse: busy=%b PE_en=%b i_config=%h, required 1 1 %h", busy, PE_en, i_config, c);
    end
    wait_done(500, seen);
    n_cmp++;
    if (!seen || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL conv_done: seen=%0b busy=%b, required 1 1", seen, busy);
    end
    n_cmp++;
    if (in_xfers - i0 != 14 || out_xfers - o0 != 4 || pe_en_cnt - p0 != 1) begin
      n_fail++;
      $display("FAIL conv_counts: in=%0d out=%0d pe_en=%0d, required 14 4 1",
               in_xfers - i0, out_xfers - o0, pe_en_cnt - p0);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL conv_after_done: busy=%b done=%b pulses=%0d, required 0 0 1", busy, done, done_cnt - d0);
    end
  endtask

  task automatic test_depthwise(input bit random_mode);
    logic [12:0] c;
    int i0, o0;
    bit seen;
    c  = {1'b1, 2'd2, 1'b1, 2'd3, 5'd0, 2'd2};
    i0 = in_xfers; o0 = out_xfers;
    rnd = random_mode;
    start_job(c);
    wait_done(random_mode ? 6000 : 500, seen);
    rnd = 1'b0;
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL dw_done_timeout: random=%0b, required done", random_mode);
    end
    n_cmp++;
    if (in_xfers - i0 != 22 || out_xfers - o0 != 4 || exp_in.size() != 0 || exp_out.size() != 0) begin
      n_fail++;
      $display("FAIL dw_counts: random=%0b in=%0d out=%0d left=%0d/%0d, required 22 4 0/0",
               random_mode, in_xfers - i0, out_xfers - o0, exp_in.size(), exp_out.size());
    end
    @(negedge clk);
  endtask

  task automatic test_start_held;
    logic [12:0] c;
    int p0, d0;
    bit seen;
    c  = 13'd0;
    p0 = pe_en_cnt; d0 = done_cnt;
    push_job(c);
    @(posedge clk); #1;
    cfg = c; start = 1'b1;
    @(posedge clk); #1;
    cfg = 13'h1FFF;
    wait_done(300, seen);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (!seen || pe_en_cnt - p0 != 1 || done_cnt - d0 != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_held: seen=%0b pe_en=%0d done=%0d busy=%b, required 1 1 1 0",
               seen, pe_en_cnt - p0, done_cnt - d0, busy);
    end
    n_cmp++;
    if (i_config !== c || exp_in.size() != 0 || exp_out.size() != 0) begin
      n_fail++;
      $display("FAIL start_held_cfg: i_config=%h left=%0d/%0d, required %h 0/0",
               i_config, exp_in.size(), exp_out.size(), c);
    end
  endtask

  task automatic test_reset_mid;
    int d0, i0, o0;
    bit seen;
    d0 = done_cnt;
    start_job({1'b1, 2'd2, 1'b1, 2'd3, 5'd0, 2'd2});
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (ifmap_valid) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rst_mid_reach_ifmap: got no ifmap phase, required one");
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (quiet_vec !== 23'd0 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %h done_pulses=%0d, required 0 0", quiet_vec, done_cnt - d0);
    end
    exp_in.delete();
    exp_out.delete();
    in_push = in_idx;
    op_push = op_idx;
    @(posedge clk); #1;
    rst = 1'b0;
    i0 = in_xfers; o0 = out_xfers;
    start_job(13'd0);
    wait_done(300, seen);
    n_cmp++;
    if (!seen || in_xfers - i0 != 3 || out_xfers - o0 != 1 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL rst_mid_rerun: seen=%0b in=%0d out=%0d done=%0d, required 1 3 1 1",
               seen, in_xfers - i0, out_xfers - o0, done_cnt - d0);
    end
    @(negedge clk);
  endtask

  task automatic test_long_cols;
    int i0, o0;
    bit seen;
    i0 = in_xfers; o0 = out_xfers;
    start_job({1'b0, 2'd0, 1'b0, 2'd0, 5'd31, 2'd0});
    wait_done(1000, seen);
    n_cmp++;
    if (!seen || out_xfers - o0 != 32 || in_xfers - i0 != 65) begin
      n_fail++;
      $display("FAIL long_cols: seen=%0b out=%0d in=%0d, required 1 32 65",
               seen, out_xfers - o0, in_xfers - i0);
    end
    @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    cfg   = 13'd0;
    test_reset();
    test_normal_conv();
    test_depthwise(1'b0);
    test_depthwise(1'b1);
    test_start_held();
    test_reset_mid();
    test_long_cols();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
